gmii_rx_frame_aligner: RTL

- First stage of the receive path. Sits directly upstream of the RX data pipeline and feeds it.
- Consumes raw GMII receive bytes and validates and strips the preamble/SFD.
- Emits payload bytes (including FCS) as a byte stream with valid, start-of-frame, end-of-frame and error markers, plus per-frame length.
- Malformed frame starts are discarded and reported.

---
 rtl/gmii_rx_frame_aligner_if.sv | 51 +++++
 rtl/gmii_rx_frame_aligner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_frame_aligner_if.sv
// gmii_rx_frame_aligner_if
// Groups the GMII receive inputs and the aligned payload stream of the
// receive frame aligner into one bundle.
//   gmii_rxd_i / gmii_rx_dv_i / gmii_rx_er_i : raw GMII receive byte lane
//   data_o / valid_o / sof_o / eof_o / err_o  : aligned payload byte stream
//   frame_len_o                               : payload length (with eof_o)
//   drop_o                                    : discarded frame attempt pulse
// Modports: master = GMII source / stream sink, slave = aligner.
interface gmii_rx_frame_aligner_if #(
    parameter int unsigned LEN_W = 16
) ();

    logic [7:0]       gmii_rxd_i;
    logic             gmii_rx_dv_i;
    logic             gmii_rx_er_i;

    logic [7:0]       data_o;
    logic             valid_o;
    logic             sof_o;
    logic             eof_o;
    logic             err_o;
    logic [LEN_W-1:0] frame_len_o;
    logic             drop_o;

    modport master (
        output gmii_rxd_i,
        output gmii_rx_dv_i,
        output gmii_rx_er_i,
        input  data_o,
        input  valid_o,
        input  sof_o,
        input  eof_o,
        input  err_o,
        input  frame_len_o,
        input  drop_o
    );

    modport slave (
        input  gmii_rxd_i,
        input  gmii_rx_dv_i,
        input  gmii_rx_er_i,
        output data_o,
        output valid_o,
        output sof_o,
        output eof_o,
        output err_o,
        output frame_len_o,
        output drop_o
    );

endinterface

// File: rtl/gmii_rx_frame_aligner.sv
// gmii_rx_frame_aligner
// First stage of the GMII receive path. Validates the 0x55 preamble run and
// the 0xD5 SFD, strips both, and forwards the remaining bytes (FCS included)
// as a byte stream with start/end/error markers and a per-frame length.
// Malformed frame starts are discarded and flagged on drop_o.
//
// Ports:
//   clk    : 125 MHz GMII RX clock
//   rst_n  : synchronous active-low reset
//   rx     : gmii_rx_frame_aligner_if.slave
//            in : gmii_rxd_i[7:0], gmii_rx_dv_i, gmii_rx_er_i
//            out: data_o[7:0], valid_o, sof_o, eof_o, err_o,
//                 frame_len_o[LEN_W-1:0], drop_o (all registered)
//
// Build option:
//   RX_MAX_LEN_CHECK_EN : when defined, frames longer than MAX_FRAME_LEN are
//                         cut at MAX_FRAME_LEN bytes and closed with err_o=1.
module gmii_rx_frame_aligner #(
    parameter int unsigned MIN_PREAMBLE  = 5,
    parameter int unsigned MAX_PREAMBLE  = 7,
    parameter int unsigned LEN_W         = 16,
    parameter int unsigned MAX_FRAME_LEN = 1522
) (
    input  logic                      clk,
    input  logic                      rst_n,
    gmii_rx_frame_aligner_if.slave    rx
);

    // Preamble counter must hold MAX_PREAMBLE+1 so the overlong case is seen
    localparam int unsigned PRE_W = $clog2(MAX_PREAMBLE + 2);

    localparam logic [7:0]       PRE_BYTE  = 8'h55;
    localparam logic [7:0]       SFD_BYTE  = 8'hD5;
    localparam logic [PRE_W-1:0] MIN_PRE_C = PRE_W'(MIN_PREAMBLE);
    localparam logic [PRE_W-1:0] MAX_PRE_C = PRE_W'(MAX_PREAMBLE);
    localparam logic [LEN_W-1:0] LEN_SAT_C = {LEN_W{1'b1}};

    // Elaboration-time sanity check of the configuration
    if (MIN_PREAMBLE == 0 || MIN_PREAMBLE > MAX_PREAMBLE ||
        MAX_FRAME_LEN == 0) begin : g_bad_cfg
        $error("gmii_rx_frame_aligner: inconsistent preamble/frame-length parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_WAIT_IDLE
    } state_e;

    state_e           state_q,   state_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]       hold_q,    hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             sof_arm_q, sof_arm_d;
    logic             err_stk_q, err_stk_d;
    logic [LEN_W-1:0] len_q,     len_d;

    logic [7:0]       data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             sof_q,     sof_d;
    logic             eof_q,     eof_d;
    logic             err_q,     err_d;
    logic [LEN_W-1:0] flen_q,    flen_d;
    logic             drop_q,    drop_d;

    logic [7:0]       rxd;
    logic             dv;
    logic             rx_er;
    logic [PRE_W-1:0] pre_inc;
    logic [LEN_W-1:0] len_inc;
    logic             len_limit;

    assign rxd   = rx.gmii_rxd_i;
    assign dv    = rx.gmii_rx_dv_i;
    assign rx_er = rx.gmii_rx_er_i;

    assign pre_inc = pre_cnt_q + PRE_W'(1);
    // Length saturates instead of wrapping on oversize frames
    assign len_inc = (len_q == LEN_SAT_C) ? len_q : len_q + LEN_W'(1);

`ifdef RX_MAX_LEN_CHECK_EN
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_FRAME_LEN);
    // Hold already contains byte MAX_FRAME_LEN, so any further byte is one too many
    assign len_limit = (len_q == MAX_LEN_C);
`else
    assign len_limit = 1'b0;
`endif

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        sof_arm_d  = sof_arm_q;
        err_stk_d  = err_stk_q;
        len_d      = len_q;

        data_d  = 8'h00;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        err_d   = 1'b0;
        flen_d  = '0;
        drop_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dv) begin
                    if (rxd == PRE_BYTE) begin
                        state_d   = S_PREAMBLE;
                        pre_cnt_d = PRE_W'(1);
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end

            S_PREAMBLE: begin
                if (!dv) begin
                    drop_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (rx_er) begin
                    drop_d  = 1'b1;
                    state_d = S_WAIT_IDLE;
                end else if (rxd == PRE_BYTE) begin
                    pre_cnt_d = pre_inc;
                    if (pre_inc > MAX_PRE_C) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else if (rxd == SFD_BYTE && pre_cnt_q >= MIN_PRE_C) begin
                    state_d    = S_PAYLOAD;
                    sof_arm_d  = 1'b1;
                    err_stk_d  = 1'b0;
                    hold_vld_d = 1'b0;
                    len_d      = '0;
                end else begin
                    drop_d  = 1'b1;
                    state_d = S_WAIT_IDLE;
                end
            end

            S_PAYLOAD: begin
                if (dv) begin
                    if (len_limit) begin
                        // Oversize: close the frame on the held byte, discard the rest
                        data_d     = hold_q;
                        valid_d    = 1'b1;
                        sof_d      = sof_arm_q;
                        eof_d      = 1'b1;
                        err_d      = 1'b1;
                        flen_d     = len_q;
                        sof_arm_d  = 1'b0;
                        hold_vld_d = 1'b0;
                        state_d    = S_WAIT_IDLE;
                    end else begin
                        // One-byte delay lets the last byte carry eof once dv falls
                        hold_d     = rxd;
                        hold_vld_d = 1'b1;
                        len_d      = len_inc;
                        if (rx_er) begin
                            err_stk_d = 1'b1;
                        end
                        if (hold_vld_q) begin
                            data_d    = hold_q;
                            valid_d   = 1'b1;
                            sof_d     = sof_arm_q;
                            sof_arm_d = 1'b0;
                        end
                    end
                end else begin
                    if (hold_vld_q) begin
                        data_d  = hold_q;
                        valid_d = 1'b1;
                        sof_d   = sof_arm_q;
                        eof_d   = 1'b1;
                        err_d   = err_stk_q;
                        flen_d  = len_q;
                    end else begin
                        // SFD followed directly by end of carrier: nothing to deliver
                        drop_d = 1'b1;
                    end
                    sof_arm_d  = 1'b0;
                    hold_vld_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end

            S_WAIT_IDLE: begin
                if (!dv) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= '0;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            sof_arm_q  <= 1'b0;
            err_stk_q  <= 1'b0;
            len_q      <= '0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
            flen_q     <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            sof_arm_q  <= sof_arm_d;
            err_stk_q  <= err_stk_d;
            len_q      <= len_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            err_q      <= err_d;
            flen_q     <= flen_d;
            drop_q     <= drop_d;
        end
    end

    assign rx.data_o      = data_q;
    assign rx.valid_o     = valid_q;
    assign rx.sof_o       = sof_q;
    assign rx.eof_o       = eof_q;
    assign rx.err_o       = err_q;
    assign rx.frame_len_o = flen_q;
    assign rx.drop_o      = drop_q;

endmodule
